// File: rtl/fifo_pkg.sv
// Shared types and helpers for the byte FIFO.
package fifo_pkg;

    // Defaults used when the FIFO is instantiated without overrides.
    localparam int unsigned FifoDefaultWidth = 8;
    localparam int unsigned FifoDefaultDepth = 8;

    // Combined access decoded for one clock edge.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Pointer address width for a given entry count.
    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, indexed combinational read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; only the FIFO pointers are.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees pre-edge contents, so a same-edge write to this slot never falls through.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and flags decoded from registered pointers.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FifoDefaultWidth,
    parameter int unsigned DEPTH = FifoDefaultDepth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wrdata,
    output logic [WIDTH-1:0] rddata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = fifo_aw(DEPTH);
    // Pointers carry an extra wrap bit to tell full from empty.
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wp_q, wp_d;
    logic [AW:0]      rp_q, rp_d;
    logic [WIDTH-1:0] rddata_q, rddata_d;
    logic [WIDTH-1:0] mem_rdata;
    logic             wr_acc;
    logic             rd_acc;
    fifo_op_e         op;

    // Status decoded purely from registered pointers: no path from wr/rd.
    always_comb begin
        empty = (wp_q == rp_q);
        full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    end

    // Accept logic; a read frees a slot on the same edge, so write-while-full is ok with rd.
    always_comb begin
        rd_acc = rd && !empty;
        wr_acc = wr && (!full || rd);
        op     = fifo_op_e'({rd_acc, wr_acc});
    end

    // Pointer and read-data next state.
    always_comb begin
        wp_d     = wp_q;
        rp_d     = rp_q;
        rddata_d = rddata_q;
        unique case (op)
            OpIdle: ;
            OpPush: begin
                wp_d = wp_q + PtrOne;
            end
            OpPop: begin
                rp_d     = rp_q + PtrOne;
                rddata_d = mem_rdata;
            end
            OpBoth: begin
                wp_d     = wp_q + PtrOne;
                rp_d     = rp_q + PtrOne;
                rddata_d = mem_rdata;
            end
            default: ;
        endcase
    end

    // Pointer and read-data registers; reset discards all stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            rddata_q <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            rddata_q <= rddata_d;
        end
    end

    assign rddata = rddata_q;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wp_q[AW-1:0]),
        .wdata_i (wrdata),
        .raddr_i (rp_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_fifo.sv
// Randomised bench for fifo against a queue-based reference model.
module tb_fifo;

    localparam int unsigned W = 8;
    localparam int unsigned D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr;
    logic         rd;
    logic [W-1:0] wrdata;
    logic [W-1:0] rddata;
    logic         empty;
    logic         full;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue, last popped word.
    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd;

    always #5 clk = ~clk;

    fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wr),
        .rd     (rd),
        .wrdata (wrdata),
        .rddata (rddata),
        .empty  (empty),
        .full   (full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model of one clock edge, from the behavioural rules.
    task automatic model_edge(input logic w, input logic r, input logic [W-1:0] d);
        bit rd_ok;
        bit wr_ok;
        if (!rst_n) begin
            q.delete();
            exp_rd = '0;
            return;
        end
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < D) || r);
        if (rd_ok) exp_rd = q.pop_front();
        if (wr_ok) q.push_back(d);
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
        wr     = w;
        rd     = r;
        wrdata = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    // Every falling edge the outputs must agree with the model.
    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            chk("cmp_empty",  {31'b0, empty}, {31'b0, (q.size() == 0)});
            chk("cmp_full",   {31'b0, full},  {31'b0, (q.size() == D)});
            chk("cmp_rddata", {24'b0, rddata}, {24'b0, exp_rd});
        end
    end

    initial begin
        logic [W-1:0] last;
        wr     = 1'b0;
        rd     = 1'b0;
        wrdata = 8'h66;
        rst_n  = 1'b0;
        q.delete();
        exp_rd = '0;

        // Reset held with inputs idle.
        repeat (3) cyc(1'b0, 1'b0, 8'h66);
        chk("rst_empty",  {31'b0, empty}, 32'd1);
        chk("rst_full",   {31'b0, full},  32'd0);
        chk("rst_rddata", {24'b0, rddata}, 32'h00);
        rst_n = 1'b1;

        // Overfill with ten writes.
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0, 8'h66);
            if (i == 1) chk("ovf_empty_fall", {31'b0, empty}, 32'd0);
            if (i == 7) chk("ovf_not_full7", {31'b0, full}, 32'd0);
            if (i == 8) chk("ovf_full8", {31'b0, full}, 32'd1);
        end
        chk("ovf_full10", {31'b0, full}, 32'd1);
        chk("ovf_count", q.size(), 32'd8);

        // Partial drain.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            if (i == 1) begin
                chk("drain_rddata", {24'b0, rddata}, 32'h66);
                chk("drain_full", {31'b0, full}, 32'd0);
            end
        end
        chk("drain_empty", {31'b0, empty}, 32'd0);
        chk("drain_count", q.size(), 32'd3);
        repeat (3) cyc(1'b0, 1'b1, 8'h00);
        chk("drain_done", {31'b0, empty}, 32'd1);

        // Ordering 0x01..0x08.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, W'(i));
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("order_rddata", {24'b0, rddata}, i);
        end
        chk("order_empty", {31'b0, empty}, 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("order_9th_read", {24'b0, rddata}, 32'h08);

        // Simultaneous access on a full FIFO.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, W'(8'h10 + i));
        cyc(1'b1, 1'b1, 8'hAA);
        chk("both_full_rd", {24'b0, rddata}, 32'h10);
        chk("both_full_flag", {31'b0, full}, 32'd1);
        repeat (8) cyc(1'b0, 1'b1, 8'h00);
        chk("both_full_last", {24'b0, rddata}, 32'hAA);
        chk("both_full_empty", {31'b0, empty}, 32'd1);

        // Simultaneous access on an empty FIFO: no fall-through.
        cyc(1'b1, 1'b1, 8'h55);
        chk("both_empty_flag", {31'b0, empty}, 32'd0);
        chk("both_empty_rd", {24'b0, rddata}, 32'hAA);
        cyc(1'b0, 1'b1, 8'h00);
        chk("both_empty_pop", {24'b0, rddata}, 32'h55);

        // Twenty interleaved cycles to wrap the pointers.
        for (int i = 0; i < 20; i++) cyc(1'b1, i[0], W'(8'h30 + i));

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, W'($urandom));
        end

        // Fill partially, then reset asynchronously between edges.
        repeat (4) cyc(1'b1, 1'b0, W'($urandom));
        cyc(1'b0, 1'b1, 8'h00);
        last = rddata;
        #2;
        rst_n = 1'b0;
        q.delete();
        exp_rd = '0;
        #1;
        chk("arst_empty",  {31'b0, empty}, 32'd1);
        chk("arst_full",   {31'b0, full},  32'd0);
        chk("arst_rddata", {24'b0, rddata}, 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (last == 8'h00) chk("arst_prev_rd", {24'b0, rddata}, 32'h00);

        // Traffic after reset.
        for (int i = 0; i < 100; i++) begin
            cyc($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, W'($urandom));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock byte FIFO for the SPI peripheral of the Cortex-M0 subsystem. It buffers 8-bit data between the bus-side register interface and the SPI shift engine, one instance per direction (TX and RX). Write and read strobes are single-cycle qualified, and the block reports empty/full status flags.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 8: number of entries. Must be a power of two, ≥2.
- `AW`, default log2(DEPTH): pointer address width. Derived; not overridden.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr`  in  1: write strobe. Each cycle it is high pushes `wrdata`.
- `rd`  in  1: read strobe. Each cycle it is high pops one entry.
- `wrdata`  in  WIDTH: write data.
- `rddata`  out  WIDTH: registered read data.
- `empty`  out  1: FIFO holds zero entries.
- `full`  out  1: FIFO holds DEPTH entries.

## Operation
- Storage is a DEPTH×WIDTH register array. It has write pointer `wp` and read pointer `rp`, each AW+1 bits wide; the extra MSB is a wrap bit.
- Entry count = `wp` − `rp` (modulo 2^(AW+1)).
  - `empty` when `wp`==`rp`.
  - `full` when the low AW bits are equal and the MSBs differ.
- Write accepted when `wr` && (!`full` || `rd`).
  - On acceptance: mem[`wp`[AW-1:0]] ← `wrdata`, and `wp` increments.
- Read accepted when `rd` && !`empty`.
  - On acceptance: `rddata` ← mem[`rp`[AW-1:0]], and `rp` increments.
- Write while full without `rd`: silently dropped. Pointers, flags and memory are unchanged.
- Read while empty: ignored. `rddata` holds its last value and `rp` is unchanged.
- Simultaneous `wr` and `rd`:
  - Not empty (including full): both are accepted and the count is unchanged. The read returns the oldest entry, never the word being written.
  - Empty: the write is accepted and the read is ignored. No fall-through.
- Pointers wrap naturally modulo 2^(AW+1); no special-case logic.
- Data order is strictly first-in first-out.
- Memory contents are not reset. Only pointers, flags and `rddata` are reset.

## Timing
- On reset assertion (asynchronous): `wp`=`rp`=0, `rddata`=0, `empty`=1, `full`=0.
- Reset mid-operation discards all stored data immediately.
- Flags are registered, or decoded from registered pointers. They reflect all accesses accepted at edge N by edge N+ε, so a write at edge N deasserts `empty` after edge N.
- Read latency is 1 cycle: with `rd` high at edge N, `rddata` is valid after edge N and holds until the next accepted read.
- Throughput is one write and one read per cycle, sustained.
- There is no combinational path from `wr`/`rd` to `empty`/`full`/`rddata`.

## Structure
- No shared package is required. `WIDTH`/`DEPTH` are supplied by the SPI top through its own parameter constants.
- One sub-module is natural: `fifo_mem`, a DEPTH×WIDTH register array with a synchronous write port and an indexed read port.
  - Pointer/flag logic stays in `fifo`.
  - Registering of `rddata` stays in `fifo`.

## Test plan
- Reset: hold `rst_n`=0 with `wr`=`rd`=0, `wrdata`=0x66 → `empty`=1, `full`=0, `rddata`=0x00 throughout.
- Overfill: after reset, `wr`=1 with `wrdata`=0x66 for 10 cycles.
  - `empty` falls after the first edge.
  - `full` rises after the 8th edge.
  - Writes 9–10 are dropped and the count stays at 8.
- Partial drain: then `rd`=1 for 5 cycles → `rddata`=0x66 after the first read edge, `full`=0 after it, 3 entries remain, `empty`=0.
- Ordering: write 0x01..0x08, then read 8 → `rddata` sequence 0x01..0x08. `empty`=1 after the 8th read. A 9th read leaves `rddata`=0x08.
- Simultaneous access:
  - Full FIFO, one cycle of `wr`+`rd` → oldest word out, new word stored, `full` stays 1.
  - Empty FIFO, `wr`+`rd` → `empty`=0, `rddata` unchanged.
- Wrap/reset: run 20 interleaved write/read cycles so the pointers wrap → data correct, flags correct. Assert `rst_n` mid-stream → immediately `empty`=1, `full`=0, `rddata`=0.
